cls_restoring_divider: RTL and testbench

- Iterative unsigned restoring divider built on the team's borrow-lookahead subtractor (4-bit p/g groups, group P/G, lookahead borrows).
- Sits directly downstream of the lookahead subtractor stage. Each iteration, the subtractor's difference and borrow-out decide whether to restore and set the quotient bit.
- Performs one trial subtraction per clock. Exposes a start/done handshake to the datapath controller.

---
 rtl/cls_restoring_divider.sv | 140 ++++++++++++++
 tb/tb_cls_restoring_divider.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cls_restoring_divider.sv
// Iterative unsigned restoring divider: one trial subtraction per clock through a
// two-level borrow-lookahead subtractor, with a start/busy/done handshake.
module cls_restoring_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int NG = WIDTH / 4;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_reg, state_next;
  // The partial remainder's top bit is always zero between iterations (A < M),
  // so only the low WIDTH bits are kept.
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] m_reg, m_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] quotient_reg, quotient_next;
  logic [WIDTH-1:0] remainder_reg, remainder_next;
  logic             dbz_reg, dbz_next;

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic [NG-1:0]    grp_p, grp_g;
  logic [NG:0]      grp_bin;
  logic             borrow_out;
  logic [WIDTH-1:0] a_iter, q_iter;

  assign trial      = {a_reg, q_reg[WIDTH-1]};
  assign grp_bin[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
      localparam int B = gi * 4;
      logic [3:0] ga, gb, p, g, bin;
      assign ga = trial[B+3:B];
      assign gb = m_reg[B+3:B];
      assign p  = ~ga | gb;
      assign g  = ~ga & gb;
      assign bin[0] = grp_bin[gi];
      assign bin[1] = g[0] | (p[0] & grp_bin[gi]);
      assign bin[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & grp_bin[gi]);
      assign bin[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & grp_bin[gi]);
      assign diff[B+3:B] = ga ^ gb ^ bin;
      assign grp_g[gi] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                       | (p[3] & p[2] & p[1] & g[0]);
      assign grp_p[gi] = &p;
      assign grp_bin[gi+1] = grp_g[gi] | (grp_p[gi] & grp_bin[gi]);
    end
  endgenerate

  // MSB stage subtracts a zero divisor bit, so only its borrow matters.
  assign borrow_out = ~trial[WIDTH] & grp_bin[NG];
  assign a_iter     = borrow_out ? trial[WIDTH-1:0] : diff;
  assign q_iter     = {q_reg[WIDTH-2:0], ~borrow_out};

  always_comb begin
    state_next     = state_reg;
    a_next         = a_reg;
    q_next         = q_reg;
    m_next         = m_reg;
    count_next     = count_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    dbz_next       = dbz_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            m_next     = divisor;
            a_next     = '0;
            q_next     = dividend;
            count_next = '0;
            dbz_next   = 1'b0;
            state_next = CALC;
          end else begin
            quotient_next  = '1;
            remainder_next = dividend;
            dbz_next       = 1'b1;
            state_next     = DONE;
          end
        end
      end
      CALC: begin
        a_next     = a_iter;
        q_next     = q_iter;
        count_next = count_reg + CW'(1);
        if (count_reg == CW'(WIDTH - 1)) begin
          quotient_next  = q_iter;
          remainder_next = a_iter;
          state_next     = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      q_reg         <= '0;
      m_reg         <= '0;
      count_reg     <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      a_reg         <= a_next;
      q_reg         <= q_next;
      m_reg         <= m_next;
      count_reg     <= count_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      dbz_reg       <= dbz_next;
    end
  end

  assign busy        = (state_reg == CALC);
  assign done        = (state_reg == DONE);
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_cls_restoring_divider.sv
// Scoreboard bench for cls_restoring_divider (WIDTH=16): directed cases, handshake
// corner cases and a random sweep against a behavioural divide model.
module tb_cls_restoring_divider;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] dividend = '0;
  logic [WIDTH-1:0] divisor = '0;
  logic             busy, done, div_by_zero;
  logic [WIDTH-1:0] quotient, remainder;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  cls_restoring_divider #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [WIDTH-1:0] dd, input logic [WIDTH-1:0] dv);
    exp_t e;
    if (dv == 0) begin
      e.q = '1; e.r = dd; e.dbz = 1'b1;
    end else begin
      e.q = dd / dv; e.r = dd % dv; e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Issues one request and waits (bounded) for done; lat = edges after the start edge, -1 on timeout.
  task automatic run_op(input logic [WIDTH-1:0] dd, input logic [WIDTH-1:0] dv,
                        output int lat, output int busy_cnt);
    exp_q.push_back(model(dd, dv));
    @(negedge clk);
    start = 1'b1; dividend = dd; divisor = dv;
    @(negedge clk);
    start = 1'b0; dividend = WIDTH'($urandom); divisor = WIDTH'($urandom);
    lat = 0; busy_cnt = 0;
    while (done !== 1'b1 && lat < 60) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) lat = -1;
    $display("op %0d / %0d -> q=%0d r=%0d dbz=%0b lat=%0d", dd, dv, quotient, remainder, div_by_zero, lat);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (quotient !== '0) begin n_fail++; $display("FAIL reset_quotient: got %0d want 0", quotient); end
    n_checks++; if (remainder !== '0) begin n_fail++; $display("FAIL reset_remainder: got %0d want 0", remainder); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
  endtask

  task automatic test_basic;
    int lat, bc;
    exp_t e;
    run_op(16'd100, 16'd7, lat, bc);
    e = exp_q.pop_front();
    n_checks++; if (lat !== WIDTH) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", lat, WIDTH); end
    n_checks++; if (bc !== WIDTH) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want %0d", bc, WIDTH); end
    n_checks++; if (quotient !== e.q) begin n_fail++; $display("FAIL basic_quotient: got %0d want %0d", quotient, e.q); end
    n_checks++; if (remainder !== e.r) begin n_fail++; $display("FAIL basic_remainder: got %0d want %0d", remainder, e.r); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL basic_dbz: got %b want 0", div_by_zero); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_edges;
    logic [WIDTH-1:0] dds[4] = '{16'hFFFF, 16'hFFFF, 16'd3, 16'd0};
    logic [WIDTH-1:0] dvs[4] = '{16'hFFFF, 16'h0001, 16'd10, 16'd5};
    int lat, bc;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      run_op(dds[i], dvs[i], lat, bc);
      e = exp_q.pop_front();
      n_checks++; if (lat !== WIDTH) begin n_fail++; $display("FAIL edge%0d_latency: got %0d want %0d", i, lat, WIDTH); end
      n_checks++; if (quotient !== e.q) begin n_fail++; $display("FAIL edge%0d_quotient: got %0h want %0h", i, quotient, e.q); end
      n_checks++; if (remainder !== e.r) begin n_fail++; $display("FAIL edge%0d_remainder: got %0h want %0h", i, remainder, e.r); end
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero;
    int lat, bc;
    exp_t e;
    run_op(16'd5, 16'd0, lat, bc);
    e = exp_q.pop_front();
    n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL dz_latency: got %0d want 0", lat); end
    n_checks++; if (bc !== 0) begin n_fail++; $display("FAIL dz_busy_cycles: got %0d want 0", bc); end
    n_checks++; if (quotient !== e.q) begin n_fail++; $display("FAIL dz_quotient: got %0h want %0h", quotient, e.q); end
    n_checks++; if (remainder !== e.r) begin n_fail++; $display("FAIL dz_remainder: got %0d want %0d", remainder, e.r); end
    n_checks++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b want 1", div_by_zero); end
    @(negedge clk);
    run_op(16'd9, 16'd3, lat, bc);
    e = exp_q.pop_front();
    n_checks++; if (quotient !== e.q) begin n_fail++; $display("FAIL dz_next_quotient: got %0d want %0d", quotient, e.q); end
    n_checks++; if (remainder !== e.r) begin n_fail++; $display("FAIL dz_next_remainder: got %0d want %0d", remainder, e.r); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dz_next_flag: got %b want 0", div_by_zero); end
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    int lat;
    exp_t e;
    exp_q.push_back(model(16'd1000, 16'd33));
    @(negedge clk); start = 1'b1; dividend = 16'd1000; divisor = 16'd33;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; dividend = 16'd7; divisor = 16'd2;
    @(negedge clk); start = 1'b0;
    lat = 5;
    while (done !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
    e = exp_q.pop_front();
    $display("op 1000 / 33 with mid-run start -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
    n_checks++; if (lat !== WIDTH) begin n_fail++; $display("FAIL ign_latency: got %0d want %0d", lat, WIDTH); end
    n_checks++; if (quotient !== e.q) begin n_fail++; $display("FAIL ign_quotient: got %0d want %0d", quotient, e.q); end
    n_checks++; if (remainder !== e.r) begin n_fail++; $display("FAIL ign_remainder: got %0d want %0d", remainder, e.r); end
    repeat (6) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_idle_busy: got %b want 0", busy); end
    n_checks++; if (quotient !== e.q || remainder !== e.r) begin
      n_fail++; $display("FAIL ign_hold: got %0d/%0d want %0d/%0d", quotient, remainder, e.q, e.r);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    exp_t e;
    run_op(16'd20, 16'd4, lat, bc);
    e = exp_q.pop_front();
    n_checks++; if (quotient !== e.q) begin n_fail++; $display("FAIL b2b_first_quotient: got %0d want %0d", quotient, e.q); end
    start = 1'b1; dividend = 16'd9; divisor = 16'd2;
    @(negedge clk); start = 1'b0;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_start_in_done: got busy=%b done=%b want 0/0", busy, done);
    end
    run_op(16'd9, 16'd2, lat, bc);
    e = exp_q.pop_front();
    n_checks++; if (lat !== WIDTH) begin n_fail++; $display("FAIL b2b_latency: got %0d want %0d", lat, WIDTH); end
    n_checks++; if (quotient !== e.q || remainder !== e.r) begin
      n_fail++; $display("FAIL b2b_result: got %0d/%0d want %0d/%0d", quotient, remainder, e.q, e.r);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    int lat, bc, done_seen;
    exp_t e;
    @(negedge clk); start = 1'b1; dividend = 16'd1000; divisor = 16'd33;
    @(negedge clk); start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort_handshake: got busy=%b done=%b want 0/0", busy, done);
    end
    n_checks++; if (quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
      n_fail++; $display("FAIL abort_outputs: got %0d/%0d/%b want 0/0/0", quotient, remainder, div_by_zero);
    end
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    $display("abort 1000 / 33 by reset -> done/busy cycles after reset=%0d", done_seen);
    n_checks++; if (done_seen !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d want 0", done_seen); end
    run_op(16'd50, 16'd6, lat, bc);
    e = exp_q.pop_front();
    n_checks++; if (quotient !== e.q || remainder !== e.r) begin
      n_fail++; $display("FAIL abort_next_result: got %0d/%0d want %0d/%0d", quotient, remainder, e.q, e.r);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    int lat, bc;
    exp_t e;
    logic [WIDTH-1:0] dd, dv;
    longint recon;
    for (int i = 0; i < 2000; i++) begin
      dd = WIDTH'($urandom);
      dv = (i % 4 == 0) ? WIDTH'($urandom_range(1, 15)) : WIDTH'($urandom_range(1, 65535));
      run_op(dd, dv, lat, bc);
      e = exp_q.pop_front();
      recon = longint'(quotient) * longint'(dv) + longint'(remainder);
      n_checks++; if (lat !== WIDTH) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, WIDTH); end
      n_checks++; if (quotient !== e.q || remainder !== e.r) begin
        n_fail++; $display("FAIL rnd%0d_result %0d/%0d: got %0d/%0d want %0d/%0d", i, dd, dv, quotient, remainder, e.q, e.r);
      end
      n_checks++; if (recon != longint'(dd) || remainder >= dv) begin
        n_fail++; $display("FAIL rnd%0d_invariant: got q*d+r=%0d r=%0d want %0d r<%0d", i, recon, remainder, dd, dv);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
